// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-byte valid/ready holding register, framing-error and overrun pulses
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_rx_frame_err,
    output logic       o_rx_overrun,
    output logic       o_rx_busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    localparam logic [CNT_W-1:0] W_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state, w_next;
    logic             r_meta, r_rxs;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             w_stop_ok, w_ferr, w_accept;

    // Two-flop synchronizer for the asynchronous pin; idles high
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_rxs  <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_rxs  <= r_meta;
        end
    end

    // FSM state and bit-timing datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next state, counter/shift updates and stop-bit verdict
    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_stop_ok   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rxs) w_next = S_START;
            end
            S_START: begin
                if (r_cnt == W_HALF) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    w_next    = r_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == W_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rxs, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == W_LAST) begin
                    w_cnt_nxt = '0;
                    w_stop_ok = r_rxs;
                    w_ferr    = !r_rxs;
                    w_next    = r_rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (r_rxs) w_next = S_IDLE;
            end
            default: begin
                w_next    = S_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // A finished byte is taken only if the holding register is empty or being drained this cycle
    assign w_accept = w_stop_ok && (!o_rx_valid || i_rx_ready);

    // Holding register, handshake and one-cycle status pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rx_data      <= '0;
            o_rx_valid     <= 1'b0;
            o_rx_frame_err <= 1'b0;
            o_rx_overrun   <= 1'b0;
        end else begin
            o_rx_frame_err <= w_ferr;
            o_rx_overrun   <= w_stop_ok && o_rx_valid && !i_rx_ready;
            if (w_accept) begin
                o_rx_data  <= r_shift;
                o_rx_valid <= 1'b1;
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

    assign o_rx_busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with a queue scoreboard checked by a decoupled monitor
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         k;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rxd          (rxd),
        .o_rx_data      (rx_data),
        .o_rx_valid     (rx_valid),
        .i_rx_ready     (ready),
        .o_rx_frame_err (frame_err),
        .o_rx_overrun   (overrun),
        .o_rx_busy      (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        exp_t e;
        e.k = k;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic take(input int k, input logic [7:0] d);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got event %0d data %0h, expected none", k, d);
        end else begin
            e = sb.pop_front();
            if (e.k != k || e.d !== d) begin
                n_fail++;
                $display("FAIL sb_event: got event %0d data %0h, expected event %0d data %0h", k, d, e.k, e.d);
            end
        end
    endtask

    task automatic monitor();
        logic pv, pr;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid && (!pv || pr)) take(K_DATA, rx_data);
            if (frame_err) take(K_FERR, 8'h00);
            if (overrun) take(K_OVR, 8'h00);
            pv = rx_valid;
            pr = ready;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rxd = stop;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!rx_valid && n < 20 * CPB) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) check(name, 0, 1);
    endtask

    task automatic consume();
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_flags", {frame_err, overrun}, 0);

        push(K_DATA, 8'h55);
        send_frame(8'h55, 1'b1);
        wait_valid("t1_timeout");
        check("t1_data", rx_data, 8'h55);
        consume();
        @(negedge clk);
        check("t1_valid_cleared", rx_valid, 0);

        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_busy_in_start", busy, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t2_busy_fell", busy, 0);
        check("t2_valid", rx_valid, 0);

        push(K_FERR, 8'h00);
        send_frame(8'hA3, 1'b0);
        repeat (24) @(posedge clk);
        @(negedge clk);
        check("t3_busy_in_break", busy, 1);
        check("t3_valid", rx_valid, 0);
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t3_busy_released", busy, 0);

        push(K_DATA, 8'h12);
        push(K_OVR, 8'h00);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t4_data_kept", rx_data, 8'h12);
        check("t4_valid_kept", rx_valid, 1);
        push(K_DATA, 8'h34);
        fork
            send_frame(8'h34, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        @(negedge clk);
        check("t4_data_replaced", rx_data, 8'h34);
        check("t4_valid_after_swap", rx_valid, 1);

        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(posedge clk);
                repeat (60) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("t5_valid", rx_valid, 0);
                check("t5_data", rx_data, 0);
                check("t5_busy", busy, 0);
                check("t5_flags", {frame_err, overrun}, 0);
                #1 reset = 1'b0;
            end
        join
        push(K_DATA, 8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_valid("t5_timeout");
        check("t5_data_after", rx_data, 8'h0F);
        consume();

        @(posedge clk);
        #1 ready = 1'b1;
        push(K_DATA, 8'h00);
        push(K_DATA, 8'hFF);
        push(K_DATA, 8'h80);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        repeat (6) @(posedge clk);
        #1 ready = 1'b0;
        @(negedge clk);
        check("t6_valid_drained", rx_valid, 0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
